la_capture_ctrl: RTL and testbench

- Logic-analyser capture controller that sits directly downstream of the sample-clock divider.
- It drives the divider's run/start input and consumes its one-cycle sample-enable pulse. On each pulse it stores the probe word into a circular capture RAM.
- It handles the pre-trigger window, trigger detection (level mask/value plus rising-edge mask) and post-trigger fill.
- When capture completes it reports the trigger address and a done flag to the CPU-side register block.

---
 rtl/la_capture_ctrl.sv | 173 +++++++++++++++++
 tb/tb_la_capture_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/la_capture_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | la_capture_ctrl : logic-analyser capture controller with pre-trigger     |
// |                   window, level/edge trigger and post-trigger fill.      |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module la_capture_ctrl #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          sample_en,
    output logic          run,
    input  logic [DW-1:0] probe,
    input  logic [DW-1:0] trig_mask,
    input  logic [DW-1:0] trig_value,
    input  logic [DW-1:0] trig_edge,
    input  logic [AW-1:0] pre_depth,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [AW-1:0] trig_addr,
    output logic          busy,
    output logic          done
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_pre  = 3'd1;
    localparam logic [2:0] c_st_wait = 3'd2;
    localparam logic [2:0] c_st_post = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;

    localparam logic [AW-1:0] c_one      = AW'(1);
    localparam logic [AW-1:0] c_all_ones = {AW{1'b1}};

    logic [2:0]    r_state;
    logic [2:0]    w_state_nx;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] r_pre_cnt;
    logic [AW-1:0] r_post_rem;
    logic [AW-1:0] r_pre_depth;
    logic [DW-1:0] r_mask;
    logic [DW-1:0] r_value;
    logic [DW-1:0] r_edge;
    logic [DW-1:0] r_prev;
    logic          r_prev_valid;

    logic          w_active;
    logic          w_start_ok;
    logic          w_capture;
    logic          w_level_hit;
    logic          w_edge_hit;
    logic          w_trigger;
    logic          w_run_nx;
    logic [AW-1:0] w_post_init;
    logic [AW-1:0] w_pre_inc;

    assign w_active   = (r_state == c_st_pre) || (r_state == c_st_wait) ||
                        (r_state == c_st_post);
    assign w_start_ok = start && !abort &&
                        ((r_state == c_st_idle) || (r_state == c_st_done));
    // An abort in the same cycle as a sample pulse cancels that write.
    assign w_capture  = sample_en && w_active && !abort;

    assign w_level_hit = (((probe ^ r_value) & r_mask) == '0);
    // Edge channels need a valid previous sample to see a 0->1 transition.
    assign w_edge_hit  = (r_edge == '0) ||
                         (r_prev_valid && ((~r_prev & probe & r_edge) == r_edge));
    assign w_trigger   = w_level_hit && w_edge_hit;

    assign w_post_init = c_all_ones - r_pre_depth;
    assign w_pre_inc   = r_pre_cnt + c_one;

    always_comb begin
        w_state_nx = r_state;
        if (abort) begin
            w_state_nx = c_st_idle;
        end else if (w_start_ok) begin
            w_state_nx = (pre_depth == '0) ? c_st_wait : c_st_pre;
        end else if (w_capture) begin
            case (r_state)
                c_st_pre: begin
                    if (w_pre_inc == r_pre_depth) begin
                        w_state_nx = c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (w_trigger) begin
                        w_state_nx = (w_post_init == '0) ? c_st_done : c_st_post;
                    end
                end
                c_st_post: begin
                    if (r_post_rem <= c_one) begin
                        w_state_nx = c_st_done;
                    end
                end
                default: begin
                    w_state_nx = r_state;
                end
            endcase
        end
    end

    assign w_run_nx = (w_state_nx == c_st_pre) || (w_state_nx == c_st_wait) ||
                      (w_state_nx == c_st_post);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_ptr        <= '0;
            r_pre_cnt    <= '0;
            r_post_rem   <= '0;
            r_pre_depth  <= '0;
            r_mask       <= '0;
            r_value      <= '0;
            r_edge       <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            run          <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            trig_addr    <= '0;
        end else begin
            r_state <= w_state_nx;
            run     <= w_run_nx;
            busy    <= w_run_nx;
            done    <= (w_state_nx == c_st_done);
            wr_en   <= 1'b0;

            if (w_start_ok) begin
                r_mask       <= trig_mask;
                r_value      <= trig_value;
                r_edge       <= trig_edge;
                r_pre_depth  <= pre_depth;
                r_ptr        <= '0;
                r_pre_cnt    <= '0;
                r_prev_valid <= 1'b0;
            end else if (w_capture) begin
                wr_en        <= 1'b1;
                wr_addr      <= r_ptr;
                wr_data      <= probe;
                r_ptr        <= r_ptr + c_one;
                r_prev       <= probe;
                r_prev_valid <= 1'b1;
                case (r_state)
                    c_st_pre: begin
                        r_pre_cnt <= w_pre_inc;
                    end
                    c_st_wait: begin
                        if (w_trigger) begin
                            trig_addr  <= r_ptr;
                            r_post_rem <= w_post_init;
                        end
                    end
                    c_st_post: begin
                        r_post_rem <= r_post_rem - c_one;
                    end
                    default: begin
                        r_post_rem <= r_post_rem;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_la_capture_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_la_capture_ctrl : directed table-driven bench for la_capture_ctrl.    |
// | Revision           : 1.0                                                 |
// +--------------------------------------------------------------------------+
module tb_la_capture_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          sample_en = 1'b0;
    logic [DW-1:0] probe = '0;
    logic [DW-1:0] trig_mask = '0;
    logic [DW-1:0] trig_value = '0;
    logic [DW-1:0] trig_edge = '0;
    logic [AW-1:0] pre_depth = '0;
    logic          run;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] trig_addr;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          st;
        logic          ab;
        logic          se;
        logic [DW-1:0] prb;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          bsy;
        logic          dn;
        logic          ct;
        logic [AW-1:0] ta;
    } vec_t;

    vec_t tbl[$];

    la_capture_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .sample_en  (sample_en),
        .run        (run),
        .probe      (probe),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .trig_edge  (trig_edge),
        .pre_depth  (pre_depth),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .trig_addr  (trig_addr),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic bsy, input logic dn);
        chk({tag, ".wr_en"}, 32'(wr_en), 32'(we));
        chk({tag, ".busy"},  32'(busy),  32'(bsy));
        chk({tag, ".run"},   32'(run),   32'(bsy));
        chk({tag, ".done"},  32'(done),  32'(dn));
        if (we) begin
            chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(addr));
            chk({tag, ".wr_data"}, 32'(wr_data), 32'(data));
        end
    endtask

    task automatic step(input logic s_st, input logic s_ab, input logic s_se,
                        input logic [DW-1:0] prb);
        start     = s_st;
        abort     = s_ab;
        sample_en = s_se;
        probe     = prb;
        tick();
        start     = 1'b0;
        abort     = 1'b0;
        sample_en = 1'b0;
    endtask

    task automatic cfg(input logic [DW-1:0] m, input logic [DW-1:0] v,
                       input logic [DW-1:0] e, input logic [AW-1:0] pd);
        trig_mask  = m;
        trig_value = v;
        trig_edge  = e;
        pre_depth  = pd;
    endtask

    task automatic add(input logic st, input logic ab, input logic se, input logic [DW-1:0] prb,
                       input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic bsy, input logic dn, input logic ct, input logic [AW-1:0] ta);
        vec_t v;
        v.st = st; v.ab = ab; v.se = se; v.prb = prb;
        v.we = we; v.addr = addr; v.data = data;
        v.bsy = bsy; v.dn = dn; v.ct = ct; v.ta = ta;
        tbl.push_back(v);
    endtask

    initial begin
        // Edge-trigger vectors: pre_depth=0, mask=0, edge=0x01.
        add(1, 0, 0, 8'h00, 0, 4'd0, 8'h00, 1, 0, 0, 4'd0);
        add(0, 0, 1, 8'h01, 1, 4'd0, 8'h01, 1, 0, 0, 4'd0);
        add(0, 0, 1, 8'h01, 1, 4'd1, 8'h01, 1, 0, 0, 4'd0);
        add(0, 0, 1, 8'h00, 1, 4'd2, 8'h00, 1, 0, 0, 4'd0);
        add(0, 0, 1, 8'h01, 1, 4'd3, 8'h01, 1, 0, 1, 4'd3);
        for (int k = 0; k < 15; k++) begin
            add(0, 0, 1, 8'(8'h80 + k), 1, 4'((4 + k) % 16), 8'(8'h80 + k),
                (k < 14), (k == 14), (k == 14), 4'd3);
        end
        add(0, 0, 1, 8'h33, 0, 4'd0, 8'h00, 0, 1, 1, 4'd3);
        add(1, 1, 1, 8'h34, 0, 4'd0, 8'h00, 0, 0, 0, 4'd0);
        add(0, 0, 1, 8'h35, 0, 4'd0, 8'h00, 0, 0, 0, 4'd0);

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk_out("reset", 0, 4'd0, 8'h00, 0, 0);
        chk("reset.wr_addr", 32'(wr_addr), 32'd0);
        chk("reset.wr_data", 32'(wr_data), 32'd0);
        chk("reset.trig_addr", 32'(trig_addr), 32'd0);

        // Level trigger on 0x0A with a 4-sample pre-trigger window
        cfg(8'hFF, 8'h0A, 8'h00, 4'd4);
        step(1, 0, 0, 8'h00);
        chk_out("lvl.start", 0, 4'd0, 8'h00, 1, 0);
        for (int i = 0; i < 22; i++) begin
            step(0, 0, 1, 8'(i));
            chk_out($sformatf("lvl.s%0d", i), 1, 4'(i % 16), 8'(i), (i < 21), (i == 21));
            if (i == 10) chk("lvl.trig_addr", 32'(trig_addr), 32'd10);
        end
        step(0, 0, 1, 8'h55);
        chk_out("lvl.after", 0, 4'd0, 8'h00, 0, 1);
        chk("lvl.ptr", 32'(dut.r_ptr), 32'd6);

        // Maximum pre-trigger: immediate trigger at the last address
        cfg(8'h00, 8'h00, 8'h00, 4'd15);
        step(1, 0, 0, 8'h00);
        chk_out("max.start", 0, 4'd0, 8'h00, 1, 0);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 8'(8'h40 + i));
            chk_out($sformatf("max.s%0d", i), 1, 4'(i), 8'(8'h40 + i), (i < 15), (i == 15));
        end
        chk("max.trig_addr", 32'(trig_addr), 32'd15);
        step(0, 0, 1, 8'h77);
        chk_out("max.after", 0, 4'd0, 8'h00, 0, 1);
        chk("max.ptr", 32'(dut.r_ptr), 32'd0);

        // Edge trigger, table driven
        cfg(8'h00, 8'h00, 8'h01, 4'd0);
        foreach (tbl[i]) begin
            start     = tbl[i].st;
            abort     = tbl[i].ab;
            sample_en = tbl[i].se;
            probe     = tbl[i].prb;
            tick();
            chk_out($sformatf("edge.v%0d", i), tbl[i].we, tbl[i].addr, tbl[i].data,
                    tbl[i].bsy, tbl[i].dn);
            if (tbl[i].ct) chk($sformatf("edge.v%0d.trig_addr", i), 32'(trig_addr), 32'(tbl[i].ta));
        end
        start = 1'b0;
        abort = 1'b0;
        sample_en = 1'b0;

        // Sparse samples, spurious start in WAIT, then abort with a coincident pulse
        cfg(8'hFF, 8'h55, 8'h00, 4'd2);
        step(1, 0, 0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 1, 8'(8'h10 + k));
            chk_out($sformatf("sparse.p%0d", k), 1, 4'(k), 8'(8'h10 + k), 1, 0);
            for (int g = 0; g < 3; g++) begin
                step((k == 4 && g == 1), 0, 0, 8'hEE);
                chk_out($sformatf("sparse.p%0d.g%0d", k, g), 0, 4'd0, 8'h00, 1, 0);
            end
        end
        step(0, 1, 1, 8'h55);
        chk_out("abort", 0, 4'd0, 8'h00, 0, 0);
        step(0, 0, 1, 8'h55);
        chk_out("abort.after", 0, 4'd0, 8'h00, 0, 0);

        // Reset during POST
        cfg(8'h00, 8'h00, 8'h00, 4'd0);
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'hA0);
        chk_out("rstpost.s0", 1, 4'd0, 8'hA0, 1, 0);
        chk("rstpost.trig_addr", 32'(trig_addr), 32'd0);
        step(0, 0, 1, 8'hA1);
        chk_out("rstpost.s1", 1, 4'd1, 8'hA1, 1, 0);
        rst = 1'b1;
        step(0, 0, 1, 8'hA2);
        rst = 1'b0;
        chk_out("rstpost.rst", 0, 4'd0, 8'h00, 0, 0);
        chk("rstpost.wr_addr", 32'(wr_addr), 32'd0);
        step(0, 0, 1, 8'hA3);
        chk_out("rstpost.after", 0, 4'd0, 8'h00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
